// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: round-robin owner of the nRegBank write port.
// Define REGARB_CLEAR_EN to build the zero-all-registers clear sequencer.
module regbank_write_arbiter #(
  parameter int N = 32,
  parameter int M = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [$clog2(M)-1:0] req0_reg,
  input  logic [N-1:0]         req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [$clog2(M)-1:0] req1_reg,
  input  logic [N-1:0]         req1_data,
  output logic                 req1_ready,
  input  logic                 clear_req,
  output logic                 busy,
  output logic                 clear_done,
  output logic [N-1:0]         Wdata,
  output logic [$clog2(M)-1:0] Wreg,
  output logic                 RegWrite
);

  localparam int IW = $clog2(M);

  typedef enum logic {
    ARB,
    CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [IW-1:0] wreg_q, wreg_d;
  logic          we_q, we_d;
  logic          clr_acc;
  logic          hs0, hs1;

`ifdef REGARB_CLEAR_EN
  logic [IW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last       = (cnt_q == IW'(M - 1));
  assign clr_acc    = (state_q == ARB) & clear_req;
  assign busy       = (state_q == CLEAR);
  assign clear_done = busy & last;
`else
  logic unused_clear;

  assign unused_clear = clear_req;
  assign clr_acc      = 1'b0;
  assign busy         = 1'b0;
  assign clear_done   = 1'b0;
`endif

  // grant: sole valid requester wins, ptr breaks ties, clear masks both
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == ARB && !clr_acc) begin
      unique case (1'b1)
        req0_valid & req1_valid: begin
          req0_ready = ~ptr_q;
          req1_ready = ptr_q;
        end
        req0_valid & ~req1_valid: req0_ready = 1'b1;
        ~req0_valid & req1_valid: req1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign hs0 = req0_valid & req0_ready;
  assign hs1 = req1_valid & req1_ready;

  // next state, pointer and registered bank-write fields
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
`ifdef REGARB_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    if (hs0) begin
      ptr_d   = 1'b1;
      wreg_d  = req0_reg;
      wdata_d = req0_data;
      we_d    = (req0_reg != '0);
    end else if (hs1) begin
      ptr_d   = 1'b0;
      wreg_d  = req1_reg;
      wdata_d = req1_data;
      we_d    = (req1_reg != '0);
    end
`ifdef REGARB_CLEAR_EN
    if (clr_acc) begin
      state_d = CLEAR;
      cnt_d   = '0;
      wreg_d  = '0;
      wdata_d = '0;
      we_d    = 1'b1;
    end else if (state_q == CLEAR) begin
      if (last) begin
        state_d = ARB;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        wreg_d = cnt_q + 1'b1;
        we_d   = 1'b1;
      end
    end
`endif
  end

  // state register; reset aborts any clear in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
`ifdef REGARB_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
`ifdef REGARB_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign Wreg     = wreg_q;
  assign Wdata    = wdata_q;
  assign RegWrite = we_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: randomized bench with a bank and arbiter model.
// Clear tests run when REGARB_CLEAR_EN is defined.
module tb_regbank_write_arbiter;

  localparam int N  = 32;
  localparam int M  = 32;
  localparam int IW = $clog2(M);

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [IW-1:0] req0_reg, req1_reg, Wreg;
  logic [N-1:0]  req0_data, req1_data, Wdata;
  logic          clear_req, busy, clear_done, RegWrite;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]  bank [M];
  logic [N-1:0]  exp_bank [M];
  logic          bank_clr = 1'b0;
  bit            m_ptr;
  logic [IW-1:0] m_wreg;
  logic [N-1:0]  m_wdata;

  regbank_write_arbiter #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .Wdata      (Wdata),
    .Wreg       (Wreg),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  // the register bank the arbiter feeds
  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < M; i++) bank[i] <= '0;
    end else if (RegWrite) begin
      bank[Wreg] <= Wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clear_req = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    m_ptr = 1'b0;
    m_wreg = '0;
    m_wdata = '0;
  endtask

  task automatic write0(input logic [IW-1:0] r, input logic [N-1:0] d);
    int w = 0;
    req0_valid = 1'b1;
    req0_reg = r;
    req0_data = d;
    #1;
    while (req0_ready !== 1'b1 && w < 8) begin
      tick;
      w++;
    end
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL write0_timeout reg %0d ready %b want 1", r, req0_ready);
    end
    tick;
    req0_valid = 1'b0;
    if (r != '0) exp_bank[r] = d;
    m_ptr = 1'b1;
    m_wreg = r;
    m_wdata = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bank_clr = 1'b1;
    for (int i = 0; i < M; i++) exp_bank[i] = '0;
    tick;
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++; $display("FAIL rst_regwrite got %b want 0", RegWrite);
    end
    checks++;
    if (Wreg !== '0) begin
      errors++; $display("FAIL rst_wreg got %0d want 0", Wreg);
    end
    checks++;
    if (Wdata !== '0) begin
      errors++; $display("FAIL rst_wdata got %0h want 0", Wdata);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (clear_done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %b want 0", clear_done);
    end
    tick;
    bank_clr = 1'b0;
    rst = 1'b0;
    m_ptr = 1'b0;
    m_wreg = '0;
    m_wdata = '0;
    tick;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++; $display("FAIL idle_regwrite got %b want 0", RegWrite);
    end
  endtask

  task automatic test_single;
    req0_valid = 1'b1;
    req0_reg = IW'(5);
    req0_data = N'(49);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready);
    end
    tick;
    req0_valid = 1'b0;
    m_ptr = 1'b1;
    m_wreg = IW'(5);
    m_wdata = N'(49);
    exp_bank[5] = N'(49);
    checks++;
    if (RegWrite !== 1'b1) begin
      errors++; $display("FAIL single_we got %b want 1", RegWrite);
    end
    checks++;
    if (Wreg !== m_wreg || Wdata !== m_wdata) begin
      errors++;
      $display("FAIL single_wr got %0d/%0d want 5/49", Wreg, Wdata);
    end
    tick;
    checks++;
    if (RegWrite !== 1'b0 || Wreg !== m_wreg) begin
      errors++;
      $display("FAIL single_hold got we %b reg %0d want 0/5", RegWrite, Wreg);
    end
    checks++;
    if (bank[5] !== exp_bank[5]) begin
      errors++; $display("FAIL single_bank got %0d want 49", bank[5]);
    end
  endtask

  task automatic test_contention;
    logic [IW-1:0] r0 [2];
    logic [IW-1:0] r1 [2];
    logic [N-1:0]  d0 [2];
    logic [N-1:0]  d1 [2];
    int gx [4];
    int wr [4];
    int wd [4];
    int i0 = 0;
    int i1 = 0;
    r0[0] = IW'(3); d0[0] = N'(9);
    r0[1] = IW'(4); d0[1] = N'(16);
    r1[0] = IW'(7); d1[0] = N'(81);
    r1[1] = IW'(8); d1[1] = N'(100);
    gx = '{0, 1, 0, 1};
    wr = '{3, 7, 4, 8};
    wd = '{9, 81, 16, 100};
    do_reset;
    for (int c = 0; c < 4; c++) begin
      req0_valid = (i0 < 2);
      if (i0 < 2) begin
        req0_reg = r0[i0];
        req0_data = d0[i0];
      end
      req1_valid = (i1 < 2);
      if (i1 < 2) begin
        req1_reg = r1[i1];
        req1_data = d1[i1];
      end
      #1;
      checks++;
      if (req0_ready !== (gx[c] == 0) || req1_ready !== (gx[c] == 1)) begin
        errors++;
        $display("FAIL cont_grant%0d got %b%b want grant %0d",
                 c, req0_ready, req1_ready, gx[c]);
      end
      tick;
      if (gx[c] == 0) i0++;
      else i1++;
      exp_bank[wr[c]] = N'(wd[c]);
      m_wreg = IW'(wr[c]);
      m_wdata = N'(wd[c]);
      checks++;
      if (RegWrite !== 1'b1 || Wreg !== m_wreg || Wdata !== m_wdata) begin
        errors++;
        $display("FAIL cont_wr%0d got %b/%0d/%0d want 1/%0d/%0d",
                 c, RegWrite, Wreg, Wdata, wr[c], wd[c]);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_ptr = 1'b0;
    tick;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bank[wr[c]] !== N'(wd[c])) begin
        errors++;
        $display("FAIL cont_bank r%0d got %0d want %0d",
                 wr[c], bank[wr[c]], wd[c]);
      end
    end
  endtask

  task automatic test_reg0;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_reg = '0;
    req1_data = N'(1234);
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL reg0_ready got %b%b want 01", req0_ready, req1_ready);
    end
    tick;
    req1_valid = 1'b0;
    m_ptr = 1'b0;
    m_wreg = '0;
    m_wdata = N'(1234);
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++; $display("FAIL reg0_we got %b want 0", RegWrite);
    end
    checks++;
    if (Wreg !== '0 || Wdata !== m_wdata) begin
      errors++;
      $display("FAIL reg0_wr got %0d/%0d want 0/1234", Wreg, Wdata);
    end
    tick;
    checks++;
    if (bank[0] !== '0) begin
      errors++; $display("FAIL reg0_bank got %0d want 0", bank[0]);
    end
  endtask

  task automatic test_random;
    bit v0 = 1'b0;
    bit v1 = 1'b0;
    bit x0, x1, ew;
    logic [IW-1:0] g0 = '0;
    logic [IW-1:0] g1 = '0;
    logic [N-1:0]  e0 = '0;
    logic [N-1:0]  e1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!v0 && $urandom_range(1, 0) == 1) begin
        v0 = 1'b1;
        g0 = IW'($urandom_range(M - 1, 0));
        e0 = $urandom;
      end
      if (!v1 && $urandom_range(1, 0) == 1) begin
        v1 = 1'b1;
        g1 = IW'($urandom_range(M - 1, 0));
        e1 = $urandom;
      end
      req0_valid = v0; req0_reg = g0; req0_data = e0;
      req1_valid = v1; req1_reg = g1; req1_data = e1;
      x0 = v0 && (!v1 || !m_ptr);
      x1 = v1 && (!v0 || m_ptr);
      #1;
      checks++;
      if (req0_ready !== x0 || req1_ready !== x1) begin
        errors++;
        $display("FAIL rand_ready c%0d got %b%b want %b%b",
                 c, req0_ready, req1_ready, x0, x1);
      end
      tick;
      ew = 1'b0;
      if (x0) begin
        ew = (g0 != '0);
        if (ew) exp_bank[g0] = e0;
        m_wreg = g0; m_wdata = e0; m_ptr = 1'b1; v0 = 1'b0;
      end else if (x1) begin
        ew = (g1 != '0);
        if (ew) exp_bank[g1] = e1;
        m_wreg = g1; m_wdata = e1; m_ptr = 1'b0; v1 = 1'b0;
      end
      checks++;
      if (RegWrite !== ew || Wreg !== m_wreg || Wdata !== m_wdata) begin
        errors++;
        $display("FAIL rand_wr c%0d got %b/%0d/%0h want %b/%0d/%0h",
                 c, RegWrite, Wreg, Wdata, ew, m_wreg, m_wdata);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    for (int i = 0; i < M; i++) begin
      checks++;
      if (bank[i] !== exp_bank[i]) begin
        errors++;
        $display("FAIL rand_bank r%0d got %0h want %0h", i, bank[i], exp_bank[i]);
      end
    end
  endtask

`ifdef REGARB_CLEAR_EN
  task automatic test_clear;
    for (int i = 1; i < M; i++) write0(IW'(i), N'((i + 2) * (i + 2)));
    tick;
    clear_req = 1'b1;
    req0_valid = 1'b1;
    req0_reg = IW'(9);
    req0_data = N'(777);
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL clr_prio got ready %b want 0", req0_ready);
    end
    tick;
    clear_req = 1'b0;
    for (int c = 0; c < M; c++) begin
      checks++;
      if (busy !== 1'b1 || RegWrite !== 1'b1) begin
        errors++;
        $display("FAIL clr_busy c%0d got %b/%b want 1/1", c, busy, RegWrite);
      end
      checks++;
      if (Wreg !== IW'(c) || Wdata !== '0) begin
        errors++;
        $display("FAIL clr_wr c%0d got %0d/%0h want %0d/0", c, Wreg, Wdata, c);
      end
      checks++;
      if (clear_done !== (c == M - 1)) begin
        errors++;
        $display("FAIL clr_done c%0d got %b want %b", c, clear_done, c == M - 1);
      end
      checks++;
      if (req0_ready !== 1'b0) begin
        errors++; $display("FAIL clr_block c%0d got %b want 0", c, req0_ready);
      end
      tick;
    end
    checks++;
    if (busy !== 1'b0 || clear_done !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_exit got %b/%b/%b want 0/0/1",
               busy, clear_done, req0_ready);
    end
    tick;
    req0_valid = 1'b0;
    for (int i = 0; i < M; i++) exp_bank[i] = '0;
    exp_bank[9] = N'(777);
    m_ptr = 1'b1;
    m_wreg = IW'(9);
    m_wdata = N'(777);
    checks++;
    if (RegWrite !== 1'b1 || Wreg !== m_wreg || Wdata !== m_wdata) begin
      errors++;
      $display("FAIL clr_after got %b/%0d/%0d want 1/9/777", RegWrite, Wreg, Wdata);
    end
    tick;
    for (int i = 0; i < M; i++) begin
      checks++;
      if (bank[i] !== exp_bank[i]) begin
        errors++;
        $display("FAIL clr_bank r%0d got %0h want %0h", i, bank[i], exp_bank[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    for (int i = 1; i < M; i++) write0(IW'(i), N'(i * 7 + 3));
    tick;
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) tick;
    checks++;
    if (busy !== 1'b1 || Wreg !== IW'(10)) begin
      errors++;
      $display("FAIL mid_pos got %b/%0d want 1/10", busy, Wreg);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort got %b/%b/%b want 0/0/0",
               RegWrite, busy, clear_done);
    end
    tick;
    tick;
    rst = 1'b0;
    m_ptr = 1'b0;
    m_wreg = '0;
    m_wdata = '0;
    for (int i = 0; i < 10; i++) exp_bank[i] = '0;
    tick;
    for (int i = 0; i < M; i++) begin
      checks++;
      if (bank[i] !== exp_bank[i]) begin
        errors++;
        $display("FAIL mid_bank r%0d got %0h want %0h", i, bank[i], exp_bank[i]);
      end
    end
  endtask
`else
  task automatic test_clear_disabled;
    clear_req = 1'b1;
    req0_valid = 1'b1;
    req0_reg = IW'(12);
    req0_data = N'(2748);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL nclr_ready got %b want 1", req0_ready);
    end
    tick;
    req0_valid = 1'b0;
    exp_bank[12] = N'(2748);
    m_ptr = 1'b1;
    m_wreg = IW'(12);
    m_wdata = N'(2748);
    checks++;
    if (RegWrite !== 1'b1 || Wreg !== m_wreg || Wdata !== m_wdata) begin
      errors++;
      $display("FAIL nclr_wr got %b/%0d/%0d want 1/12/2748", RegWrite, Wreg, Wdata);
    end
    for (int c = 0; c < M + 4; c++) begin
      tick;
      checks++;
      if (RegWrite !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) begin
        errors++;
        $display("FAIL nclr_idle c%0d got %b/%b/%b want 0/0/0",
                 c, RegWrite, busy, clear_done);
      end
    end
    clear_req = 1'b0;
    for (int i = 0; i < M; i++) begin
      checks++;
      if (bank[i] !== exp_bank[i]) begin
        errors++;
        $display("FAIL nclr_bank r%0d got %0h want %0h", i, bank[i], exp_bank[i]);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_req = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_reg = '0;
    req1_reg = '0;
    req0_data = '0;
    req1_data = '0;
    test_reset;
    test_single;
    test_contention;
    test_reg0;
    test_random;
`ifdef REGARB_CLEAR_EN
    test_clear;
    test_reset_mid_clear;
`else
    test_clear_disabled;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
